data_sram_like_slave: RTL



---
 rtl/sram_like_pkg.sv | 62 ++++++
 rtl/data_sram_like_slave_if.sv | 27 ++
 rtl/sram_like_req_queue.sv | 97 +++++++++
 rtl/data_sram_like_slave.sv | 107 ++++++++++
 4 files changed

// File: rtl/sram_like_pkg.sv
// Shared types for the data-side SRAM-like responder: size encodings, the
// queued request entry and the byte-enable / alignment helpers.
// No ports (package).
package sram_like_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned WIDX_W = 30;   // widest possible word index; top truncates to AW
    localparam int unsigned TMR_W  = 3;    // holds LAT-1 for LAT up to 7

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'd0,
        SZ_HALF    = 2'd1,
        SZ_WORD    = 2'd2,
        SZ_ILLEGAL = 2'd3
    } size_e;

    // One outstanding request as held in the response queue.
    typedef struct packed {
        logic              wr;
        logic [WIDX_W-1:0] widx;
        logic [1:0]        off;
        size_e             size;
        logic [STRB_W-1:0] wstrb;
        logic [WORD_W-1:0] wdata;
        logic [TMR_W-1:0]  timer;
    } req_entry_t;

    // Byte enables a well-formed store of this size/offset must carry.
    function automatic logic [STRB_W-1:0] exp_wstrb(input logic [1:0] size,
                                                    input logic [1:0] off);
        logic [STRB_W-1:0] m;
        m = '0;
        case (size)
            SZ_BYTE: m = STRB_W'(4'b0001) << off;
            SZ_HALF: m = STRB_W'(4'b0011) << off;
            SZ_WORD: m = STRB_W'(4'b1111);
            default: m = '0;
        endcase
        return m;
    endfunction

    // True when a request violates size/offset alignment or store byte enables.
    function automatic logic is_malformed(input logic              wr,
                                          input logic [1:0]        size,
                                          input logic [1:0]        off,
                                          input logic [STRB_W-1:0] wstrb);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        if (wr && (wstrb != exp_wstrb(size, off))) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/data_sram_like_slave_if.sv
// SRAM-like data bus between the EX/MEM initiator and the memory responder.
// Request: req, wr, size, addr, wstrb, wdata (initiator -> responder).
// Response: addr_ok, data_ok, rdata (responder -> initiator).
interface data_sram_like_slave_if;
    import sram_like_pkg::*;

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [WORD_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [WORD_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [WORD_W-1:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_like_req_queue.sv
// In-order queue of outstanding SRAM-like requests with per-entry latency
// timers that age concurrently.
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   push_i           enqueue push_entry_i at the tail (caller guarantees not full)
//   push_entry_i     request entry, timer preloaded by the caller
//   pop_i            retire the head entry (caller guarantees head_ready_o)
//   cnt_o            number of valid entries
//   head_ready_o     head is valid and its timer has expired
//   head_o           head entry contents
module sram_like_req_queue
    import sram_like_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           push_i,
    input  req_entry_t                     push_entry_i,
    input  logic                           pop_i,
    output logic [$clog2(DEPTH + 1)-1:0]   cnt_o,
    output logic                           head_ready_o,
    output req_entry_t                     head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    req_entry_t       ent_q [DEPTH];
    req_entry_t       ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Circular increment that also works when DEPTH is 1.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next-state: age timers, then apply pop and push independently.
    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;

        for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_q[i] && (ent_q[i].timer != '0)) begin
                ent_d[i].timer = ent_q[i].timer - TMR_W'(1);
            end
        end

        if (pop_i) begin
            vld_d[head_q] = 1'b0;
            head_d        = next_ptr(head_q);
        end

        // The tail slot is never the popped slot: push requires cnt < DEPTH.
        if (push_i) begin
            ent_d[tail_q] = push_entry_i;
            vld_d[tail_q] = 1'b1;
            tail_d        = next_ptr(tail_q);
        end

        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_q[i] <= '0;
            end
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o        = cnt_q;
    assign head_o       = ent_q[head_q];
    assign head_ready_o = vld_q[head_q] && (ent_q[head_q].timer == '0);

endmodule

// File: rtl/data_sram_like_slave.sv
// Responder for the data-side SRAM-like bus: accepts requests into a bounded
// in-order queue, answers each after at least LAT cycles with one data_ok
// pulse, and backs loads/stores with a word-organised RAM.
// Ports:
//   clk, resetn    clock, synchronous active-low reset
//   bus            SRAM-like slave modport (req/addr_ok, data_ok/rdata)
//   resp_stall     holds back the head response while high
//   err_misalign   sticky flag for malformed accepted requests
module data_sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int unsigned AW    = 14,
    parameter int unsigned LAT   = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    data_sram_like_slave_if.slave        bus,
    input  logic                         resp_stall,
    output logic                         err_misalign
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned WORDS = 1 << AW;

    logic [CNT_W-1:0]  cnt;
    logic              push;
    logic              pop;
    logic              head_ready;
    req_entry_t        push_entry;
    req_entry_t        head;
    logic [AW-1:0]     head_idx;
    logic [WORD_W-1:0] mem_q [WORDS];
    logic              err_q, err_d;
    logic              unused_bits;

    // Accept only from registered occupancy; a full queue never accepts,
    // even in a cycle where the head retires.
    assign bus.addr_ok = resetn & (cnt != CNT_W'(DEPTH));
    assign push        = bus.req & bus.addr_ok;
    assign pop         = resetn & head_ready & ~resp_stall;

    // Build the entry to enqueue; address bits above the RAM span alias away.
    always_comb begin
        push_entry       = '0;
        push_entry.wr    = bus.wr;
        push_entry.widx  = WIDX_W'(bus.addr[AW+1:2]);
        push_entry.off   = bus.addr[1:0];
        push_entry.size  = size_e'(bus.size);
        push_entry.wstrb = bus.wstrb;
        push_entry.wdata = bus.wdata;
        push_entry.timer = TMR_W'(LAT - 1);
    end

    sram_like_req_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .resetn       (resetn),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .cnt_o        (cnt),
        .head_ready_o (head_ready),
        .head_o       (head)
    );

    assign head_idx = head.widx[AW-1:0];

    // Response: full word for loads, zero for stores and idle cycles.
    assign bus.data_ok = pop;
    assign bus.rdata   = (pop && !head.wr) ? mem_q[head_idx] : '0;

    // Stores take effect when they retire, so later loads see them in order.
    always_ff @(posedge clk) begin
        if (resetn && pop && head.wr) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (head.wstrb[b]) begin
                    mem_q[head_idx][8*b +: 8] <= head.wdata[8*b +: 8];
                end
            end
        end
    end

    // Sticky malformed-request flag; the request itself is still served.
    always_comb begin
        err_d = err_q;
        if (push && is_malformed(bus.wr, bus.size, bus.addr[1:0], bus.wstrb)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_misalign = err_q & resetn;

    // Address/entry bits that are carried but intentionally not consumed.
    assign unused_bits = ^{bus.addr[WORD_W-1:AW+2], head.off, head.size,
                           head.widx[WIDX_W-1:AW]};

endmodule
